// File: rtl/qcw_pkg.sv
// Shared definitions for the QCW burst sequencer: state encoding, register
// map, field positions and the config/status bundles passed between blocks.
package qcw_pkg;

  localparam int ADDR_RANGE = 32;
  localparam int LVL_W      = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_COOL  = 3'd3,
    ST_FAULT = 3'd4
  } qcw_state_e;

  // Word offsets inside the decoded window
  localparam logic [4:0] OFS_CTRL     = 5'h00;
  localparam logic [4:0] OFS_LEVEL    = 5'h04;
  localparam logic [4:0] OFS_RAMP_DIV = 5'h08;
  localparam logic [4:0] OFS_HOLD     = 5'h0C;
  localparam logic [4:0] OFS_COOL     = 5'h10;
  localparam logic [4:0] OFS_LIMIT    = 5'h14;
  localparam logic [4:0] OFS_STATUS   = 5'h18;

  // Field positions
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_TRIG_BIT  = 1;
  localparam int LVL_START_LSB  = 0;
  localparam int LVL_END_LSB    = 16;
  localparam int STAT_FAULT_BIT = 4;
  localparam int STAT_CNT_LSB   = 16;

  typedef struct packed {
    logic             enable;
    logic             trigger;     // one-cycle pulse, registered write
    logic [LVL_W-1:0] lvl_start;
    logic [LVL_W-1:0] lvl_end;
    logic [15:0]      ramp_div;
    logic [23:0]      hold_cycles;
    logic [23:0]      cool_cycles;
    logic [15:0]      burst_limit;
  } qcw_cfg_t;

  typedef struct packed {
    qcw_state_e  state;
    logic        fault;
    logic [15:0] burst_count;
  } qcw_status_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/qcw_regfile.sv
// Bus decode and register storage for the QCW sequencer. Produces a one-cycle
// acknowledge per request, the self-clearing trigger pulse and the STATUS
// write strobe used by the FSM to clear fault and burst count.
module qcw_regfile
  import qcw_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic        mem_ready_o,
  output logic [31:0] mem_rdata_o,
  input  qcw_status_t status,
  input  logic        en_clr,
  output qcw_cfg_t    cfg,
  output logic        stat_clr
);

  logic [31:0] offset;
  logic [4:0]  ofs;
  logic        hit, hit_q, acc, wr;
  logic [31:0] rd_mux;
  qcw_cfg_t    cfg_q;
  logic        unused_bits;

  // Subtraction keeps the range test correct for any base alignment
  assign offset = mem_addr_i - BASE_ADDR;
  assign ofs    = {offset[4:2], 2'b00};
  assign hit    = mem_valid_i && (offset < 32'(ADDR_RANGE));
  // First cycle of a matching request; held requests are not re-acknowledged
  assign acc    = hit && !hit_q;
  assign wr     = acc && (|mem_wstrb_i);
  assign stat_clr = wr && (ofs == OFS_STATUS);
  assign cfg    = cfg_q;

  assign unused_bits = ^{offset[1:0], mem_wdata_i[31:26]};

  // Read data selection for the decoded word
  always_comb begin
    rd_mux = 32'd0;
    case (ofs)
      OFS_CTRL:     rd_mux = {31'd0, cfg_q.enable};
      OFS_LEVEL:    rd_mux = {6'd0, cfg_q.lvl_end, 6'd0, cfg_q.lvl_start};
      OFS_RAMP_DIV: rd_mux = {16'd0, cfg_q.ramp_div};
      OFS_HOLD:     rd_mux = {8'd0, cfg_q.hold_cycles};
      OFS_COOL:     rd_mux = {8'd0, cfg_q.cool_cycles};
      OFS_LIMIT:    rd_mux = {16'd0, cfg_q.burst_limit};
      OFS_STATUS:   rd_mux = {status.burst_count, 11'd0, status.fault, 1'b0, status.state};
      default:      rd_mux = 32'd0;
    endcase
  end

  // Handshake, read capture and register writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_q       <= 1'b0;
      mem_ready_o <= 1'b0;
      mem_rdata_o <= 32'd0;
      cfg_q       <= '0;
    end else begin
      hit_q         <= hit;
      mem_ready_o   <= acc;
      mem_rdata_o   <= acc ? rd_mux : 32'd0;
      cfg_q.trigger <= wr && (ofs == OFS_CTRL) && mem_wdata_i[CTRL_TRIG_BIT];
      if (wr && (ofs == OFS_CTRL))
        cfg_q.enable <= mem_wdata_i[CTRL_EN_BIT];
      else if (en_clr)
        cfg_q.enable <= 1'b0;
      if (wr) begin
        case (ofs)
          OFS_LEVEL: begin
            cfg_q.lvl_start <= mem_wdata_i[LVL_START_LSB +: LVL_W];
            cfg_q.lvl_end   <= mem_wdata_i[LVL_END_LSB +: LVL_W];
          end
          OFS_RAMP_DIV: cfg_q.ramp_div    <= mem_wdata_i[15:0];
          OFS_HOLD:     cfg_q.hold_cycles <= mem_wdata_i[23:0];
          OFS_COOL:     cfg_q.cool_cycles <= mem_wdata_i[23:0];
          OFS_LIMIT:    cfg_q.burst_limit <= mem_wdata_i[15:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/qcw_burst_sequencer.sv
// QCW burst sequencer: start pulse, linear drive ramp, flat hold and cooldown,
// with over-current abort into a sticky fault state cleared by software.
module qcw_burst_sequencer
  import qcw_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_valid_i,
  output logic             mem_ready_o,
  input  logic [31:0]      mem_addr_i,
  input  logic [31:0]      mem_wdata_i,
  input  logic [3:0]       mem_wstrb_i,
  output logic [31:0]      mem_rdata_o,
  input  logic             ocd_halt,
  output logic             qcw_start,
  output logic             qcw_run,
  output logic [LVL_W-1:0] drive_level,
  output logic             fault_irq
);

  qcw_cfg_t    cfg;
  qcw_status_t status;
  logic        stat_clr, en_clr;

  qcw_state_e       state_q, state_n;
  logic [LVL_W-1:0] lvl_q, lvl_n, lvl_inc;
  logic [15:0]      div_q, div_n, cnt_q, cnt_n;
  logic [23:0]      cyc_q, cyc_n;
  logic             fault_q, fault_n, start_q, start_n;
  logic             ramp_wrap, hold_done, cool_done, limit_hit;

  qcw_regfile #(.BASE_ADDR(BASE_ADDR)) u_regs (
    .clk         (clk),
    .reset       (reset),
    .mem_valid_i (mem_valid_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_wstrb_i (mem_wstrb_i),
    .mem_ready_o (mem_ready_o),
    .mem_rdata_o (mem_rdata_o),
    .status      (status),
    .en_clr      (en_clr),
    .cfg         (cfg),
    .stat_clr    (stat_clr)
  );

  assign status.state       = state_q;
  assign status.fault       = fault_q;
  assign status.burst_count = cnt_q;

  assign qcw_run     = (state_q == ST_RAMP) || (state_q == ST_HOLD);
  assign qcw_start   = start_q;
  assign drive_level = lvl_q;
  assign fault_irq   = fault_q;

  // >= comparisons keep the FSM moving even if config shrinks mid-count
  assign ramp_wrap = div_q >= cfg.ramp_div;
  assign lvl_inc   = (lvl_q < cfg.lvl_end) ? lvl_q + 10'd1 : lvl_q;
  assign hold_done = ({1'b0, cyc_q} + 25'd1) >= {1'b0, cfg.hold_cycles};
  assign cool_done = ({1'b0, cyc_q} + 25'd1) >= {1'b0, cfg.cool_cycles};
  assign limit_hit = (cfg.burst_limit != 16'd0) && (cnt_q >= cfg.burst_limit);

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      lvl_q   <= '0;
      div_q   <= '0;
      cyc_q   <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_n;
      lvl_q   <= lvl_n;
      div_q   <= div_n;
      cyc_q   <= cyc_n;
      cnt_q   <= cnt_n;
      fault_q <= fault_n;
      start_q <= start_n;
    end
  end

  // Next-state, counters and sticky fault
  always_comb begin
    state_n = state_q;
    lvl_n   = lvl_q;
    div_n   = div_q;
    cyc_n   = cyc_q;
    cnt_n   = cnt_q;
    start_n = 1'b0;
    en_clr  = 1'b0;
    fault_n = fault_q;
    // A simultaneous halt keeps the fault set
    if (stat_clr && !ocd_halt) fault_n = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg.enable || cfg.trigger) begin
          state_n = ST_RAMP;
          start_n = 1'b1;
          lvl_n   = cfg.lvl_start;
          div_n   = '0;
        end
      end
      ST_RAMP: begin
        if (ocd_halt) begin
          state_n = ST_FAULT;
          lvl_n   = '0;
          fault_n = 1'b1;
        end else if (ramp_wrap) begin
          div_n = '0;
          lvl_n = lvl_inc;
          if (lvl_inc >= cfg.lvl_end) begin
            state_n = ST_HOLD;
            cyc_n   = '0;
          end
        end else begin
          div_n = div_q + 16'd1;
        end
      end
      ST_HOLD: begin
        if (ocd_halt) begin
          state_n = ST_FAULT;
          lvl_n   = '0;
          fault_n = 1'b1;
        end else if (hold_done) begin
          state_n = ST_COOL;
          cyc_n   = '0;
          lvl_n   = '0;
          cnt_n   = sat_inc16(cnt_q);
        end else begin
          cyc_n = cyc_q + 24'd1;
        end
      end
      ST_COOL: begin
        if (cool_done) begin
          if (limit_hit) begin
            en_clr  = 1'b1;
            state_n = ST_IDLE;
          end else if (cfg.enable) begin
            state_n = ST_RAMP;
            start_n = 1'b1;
            lvl_n   = cfg.lvl_start;
            div_n   = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cyc_n = cyc_q + 24'd1;
        end
      end
      ST_FAULT: begin
        if (stat_clr && !ocd_halt) state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        lvl_n   = '0;
      end
    endcase

    if (stat_clr) cnt_n = '0;
  end

endmodule

// File: tb/tb_qcw_burst_sequencer.sv
// Directed and randomized checks of the QCW burst sequencer against a
// cycle-indexed burst model derived from the ramp/hold/cool rules.
module tb_qcw_burst_sequencer;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_valid_i = 1'b0;
  logic        mem_ready_o;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic [3:0]  mem_wstrb_i = '0;
  logic [31:0] mem_rdata_o;
  logic        ocd_halt = 1'b0;
  logic        qcw_start;
  logic        qcw_run;
  logic [9:0]  drive_level;
  logic        fault_irq;

  int n_chk = 0;
  int n_fail = 0;
  int start_cnt = 0;
  int model_cnt = 0;

  qcw_burst_sequencer #(.BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_valid_i (mem_valid_i),
    .mem_ready_o (mem_ready_o),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_wstrb_i (mem_wstrb_i),
    .mem_rdata_o (mem_rdata_o),
    .ocd_halt    (ocd_halt),
    .qcw_start   (qcw_start),
    .qcw_run     (qcw_run),
    .drive_level (drive_level),
    .fault_irq   (fault_irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (qcw_start === 1'b1) start_cnt <= start_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] ofs, input logic [31:0] data);
    mem_valid_i = 1'b1; mem_addr_i = BASE + ofs; mem_wdata_i = data; mem_wstrb_i = 4'hF;
    tick();
    chk("wr_ready", 32'(mem_ready_o), 32'd1);
    mem_valid_i = 1'b0; mem_wstrb_i = 4'h0;
    tick();
  endtask

  task automatic read_chk(input string tag, input logic [31:0] ofs, input logic [31:0] exp);
    logic [31:0] d;
    mem_valid_i = 1'b1; mem_addr_i = BASE + ofs; mem_wstrb_i = 4'h0;
    tick();
    chk("rd_ready", 32'(mem_ready_o), 32'd1);
    d = mem_rdata_o;
    mem_valid_i = 1'b0;
    tick();
    chk("rd_idle_zero", mem_rdata_o, 32'd0);
    chk(tag, d, exp);
  endtask

  function automatic logic [31:0] status_word(input int st, input int flt, input int cnt);
    return 32'((cnt << 16) | (flt << 4) | st);
  endfunction

  task automatic cfg_write(input int s, input int e, input int d, input int h, input int c);
    bus_write(32'h04, 32'((e << 16) | s));
    bus_write(32'h08, 32'(d));
    bus_write(32'h0C, 32'(h));
    bus_write(32'h10, 32'(c));
  endtask

  // Called just after the edge that enters RAMP; walks one whole burst and
  // returns just after the edge that leaves COOL.
  task automatic run_burst(input int s, input int e, input int d, input int h, input int c);
    int rl, hl, cl, lvl, run;
    rl = (e > s) ? (e - s) * (d + 1) : d + 1;
    hl = (h == 0) ? 1 : h;
    cl = (c == 0) ? 1 : c;
    for (int k = 0; k < rl + hl + cl; k++) begin
      if (k < rl) begin
        lvl = (e > s) ? s + k / (d + 1) : s; run = 1;
      end else if (k < rl + hl) begin
        lvl = (e > s) ? e : s; run = 1;
      end else begin
        lvl = 0; run = 0;
      end
      chk("burst_start", 32'(qcw_start), 32'(k == 0));
      chk("burst_run", 32'(qcw_run), 32'(run));
      chk("burst_level", 32'(drive_level), 32'(lvl));
      tick();
    end
    if (model_cnt < 65535) model_cnt++;
  endtask

  initial begin
    int s, e, d, h, c, s0;

    // Reset state
    tick(); tick();
    chk("rst_start", 32'(qcw_start), 32'd0);
    chk("rst_run", 32'(qcw_run), 32'd0);
    chk("rst_level", 32'(drive_level), 32'd0);
    chk("rst_fault", 32'(fault_irq), 32'd0);
    chk("rst_ready", 32'(mem_ready_o), 32'd0);
    #2 reset = 1'b1;
    tick();
    read_chk("rst_status", 32'h18, 32'd0);

    // Single triggered burst from the reference example
    cfg_write(10, 20, 3, 5, 4);
    read_chk("level_rb", 32'h04, 32'h0014_000A);
    read_chk("rdiv_rb", 32'h08, 32'd3);
    s0 = start_cnt;
    bus_write(32'h00, 32'h2);
    run_burst(10, 20, 3, 5, 4);
    tick();
    chk("t1_idle_run", 32'(qcw_run), 32'd0);
    read_chk("t1_status", 32'h18, status_word(0, 0, model_cnt));
    read_chk("t1_ctrl", 32'h00, 32'd0);
    chk("t1_starts", 32'(start_cnt - s0), 32'd1);

    // Register field widths, reserved word, out-of-range decode
    bus_write(32'h04, 32'hFFFF_FFFF);
    read_chk("level_mask", 32'h04, 32'h03FF_03FF);
    bus_write(32'h0C, 32'hFFFF_FFFF);
    read_chk("hold_mask", 32'h0C, 32'h00FF_FFFF);
    bus_write(32'h1C, 32'hDEAD_BEEF);
    read_chk("reserved", 32'h1C, 32'd0);
    mem_valid_i = 1'b1; mem_addr_i = BASE + 32'h20; mem_wstrb_i = 4'hF;
    tick();
    chk("oor_noack", 32'(mem_ready_o), 32'd0);
    mem_valid_i = 1'b0; mem_wstrb_i = 4'h0;
    tick();

    // Continuous bursting stopped by BURST_LIMIT
    bus_write(32'h18, 32'd0); model_cnt = 0;
    bus_write(32'h14, 32'd3);
    cfg_write(100, 104, 1, 2, 3);
    s0 = start_cnt;
    bus_write(32'h00, 32'h1);
    repeat (3) run_burst(100, 104, 1, 2, 3);
    tick(); tick();
    chk("lim_run", 32'(qcw_run), 32'd0);
    read_chk("lim_ctrl", 32'h00, 32'd0);
    read_chk("lim_status", 32'h18, status_word(0, 0, 3));
    chk("lim_starts", 32'(start_cnt - s0), 32'd3);
    bus_write(32'h14, 32'd0);

    // Randomized single bursts
    for (int i = 0; i < 6; i++) begin
      s = int'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0) begin
        e = s - int'($urandom_range(0, 5));
        if (e < 0) e = 0;
      end else begin
        e = s + int'($urandom_range(1, 12));
        if (e > 1023) e = 1023;
      end
      d = int'($urandom_range(0, 3));
      h = int'($urandom_range(0, 6));
      c = int'($urandom_range(0, 4));
      cfg_write(s, e, d, h, c);
      bus_write(32'h00, 32'h2);
      run_burst(s, e, d, h, c);
    end
    read_chk("rnd_status", 32'h18, status_word(0, 0, model_cnt));

    // end <= start: one divider period at start level, then hold
    cfg_write(10, 5, 2, 0, 0);
    bus_write(32'h00, 32'h2);
    run_burst(10, 5, 2, 0, 0);

    // Over-current abort mid-ramp
    cfg_write(50, 60, 2, 3, 2);
    bus_write(32'h00, 32'h2);
    repeat (7) tick();
    chk("pre_halt_run", 32'(qcw_run), 32'd1);
    ocd_halt = 1'b1;
    tick();
    ocd_halt = 1'b0;
    chk("halt_run", 32'(qcw_run), 32'd0);
    chk("halt_level", 32'(drive_level), 32'd0);
    chk("halt_irq", 32'(fault_irq), 32'd1);
    read_chk("halt_status", 32'h18, status_word(4, 1, model_cnt));
    ocd_halt = 1'b1;
    bus_write(32'h18, 32'd0); model_cnt = 0;
    ocd_halt = 1'b0;
    read_chk("halt_wins", 32'h18, status_word(4, 1, 0));
    chk("halt_wins_irq", 32'(fault_irq), 32'd1);
    bus_write(32'h18, 32'd0);
    read_chk("fault_clr", 32'h18, status_word(0, 0, 0));
    chk("fault_clr_irq", 32'(fault_irq), 32'd0);
    ocd_halt = 1'b1;
    tick(); tick();
    ocd_halt = 1'b0;
    chk("idle_halt_irq", 32'(fault_irq), 32'd0);
    read_chk("idle_halt_st", 32'h18, 32'd0);

    // Trigger rewritten during HOLD: no second burst (6 ramp + 20 hold + 3 cool)
    cfg_write(200, 203, 1, 20, 3);
    s0 = start_cnt;
    bus_write(32'h00, 32'h2);
    repeat (8) tick();
    chk("hold_run", 32'(qcw_run), 32'd1);
    chk("hold_level", 32'(drive_level), 32'd203);
    bus_write(32'h00, 32'h2);
    repeat (19 + 5) tick();
    model_cnt++;
    chk("retrig_run", 32'(qcw_run), 32'd0);
    chk("retrig_starts", 32'(start_cnt - s0), 32'd1);
    read_chk("retrig_status", 32'h18, status_word(0, 0, model_cnt));

    // Enable cleared mid-ramp: burst completes, then idle (6 + 2 + 3 cycles)
    cfg_write(200, 203, 1, 2, 3);
    s0 = start_cnt;
    bus_write(32'h00, 32'h1);
    tick();
    bus_write(32'h00, 32'h0);
    chk("en_clr_run", 32'(qcw_run), 32'd1);
    repeat (8 + 6) tick();
    model_cnt++;
    chk("en_clr_idle", 32'(qcw_run), 32'd0);
    chk("en_clr_starts", 32'(start_cnt - s0), 32'd1);
    read_chk("en_clr_status", 32'h18, status_word(0, 0, model_cnt));

    // Asynchronous reset during HOLD
    cfg_write(300, 302, 0, 10, 2);
    bus_write(32'h14, 32'd7);
    bus_write(32'h00, 32'h2);
    repeat (4) tick();
    chk("pre_rst_run", 32'(qcw_run), 32'd1);
    chk("pre_rst_level", 32'(drive_level), 32'd302);
    #2 reset = 1'b0;
    #1;
    chk("arst_run", 32'(qcw_run), 32'd0);
    chk("arst_level", 32'(drive_level), 32'd0);
    chk("arst_start", 32'(qcw_start), 32'd0);
    chk("arst_irq", 32'(fault_irq), 32'd0);
    #2 reset = 1'b1;
    tick();
    for (int a = 0; a < 32; a += 4) read_chk("post_rst_reg", 32'(a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
